// File: rtl/operand_fetch_pkg.sv
// Shared types and sizes for the operand fetch stage and the register file.
// Both sides use them so their index and data widths always agree.
package operand_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  // x0 reads as zero, and a same-cycle writeback wins over the stale register-file read.
  function automatic xlen_t resolve_operand(
    input reg_addr_t idx,
    input logic      wb_valid,
    input reg_addr_t wb_addr,
    input xlen_t     wb_data,
    input xlen_t     rf_data
  );
    if (idx == '0)
      return '0;
    else if (wb_valid && (wb_addr == idx))
      return wb_data;
    else
      return rf_data;
  endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Busy bit per architectural register. A register is busy while a write to it is pending.
// When a set and a clear hit the same index in one cycle, the set wins.
module operand_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  reg_addr_t           set_addr,
  input  logic                clr_en,
  input  reg_addr_t           clr_addr,
  input  logic                flush_clr_en,
  input  reg_addr_t           flush_clr_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (clr_en)       busy_next[clr_addr]       = 1'b0;
    if (flush_clr_en) busy_next[flush_clr_addr] = 1'b0;
    if (set_en)       busy_next[set_addr]       = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: resolves source operands through the register file or writeback bypass,
// stalls on RAW/WAW hazards tracked by the scoreboard, and holds one entry for execute.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  reg_addr_t            in_rs1,
  input  reg_addr_t            in_rs2,
  input  reg_addr_t            in_rd,
  input  logic                 in_uses_rs1,
  input  logic                 in_uses_rs2,
  input  logic                 in_rd_wen,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output reg_addr_t            rf_read_addr_a,
  output reg_addr_t            rf_read_addr_b,
  input  xlen_t                rf_read_data_a,
  input  xlen_t                rf_read_data_b,
  input  logic                 wb_valid,
  input  reg_addr_t            wb_addr,
  input  xlen_t                wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output xlen_t                out_rs1_data,
  output xlen_t                out_rs2_data,
  output reg_addr_t            out_rd,
  output logic                 out_rd_wen,
  output logic [PAYLOAD_W-1:0] out_payload
);

  logic [NUM_REGS-1:0] busy;
  logic                raw_rs1, raw_rs2, waw_rd, hazard, accept;
  xlen_t               rs1_val, rs2_val;

  assign rf_read_addr_a = in_rs1;
  assign rf_read_addr_b = in_rs2;

  // A writeback landing this cycle resolves the hazard because its data is bypassed.
  assign raw_rs1 = in_uses_rs1 && (in_rs1 != '0) && busy[in_rs1]
                   && !(wb_valid && (wb_addr == in_rs1));
  assign raw_rs2 = in_uses_rs2 && (in_rs2 != '0) && busy[in_rs2]
                   && !(wb_valid && (wb_addr == in_rs2));
  assign waw_rd  = in_rd_wen && (in_rd != '0) && busy[in_rd]
                   && !(wb_valid && (wb_addr == in_rd));
  assign hazard  = raw_rs1 || raw_rs2 || waw_rd;

  assign in_ready = !reset && (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  assign rs1_val = resolve_operand(in_rs1, wb_valid, wb_addr, wb_data, rf_read_data_a);
  assign rs2_val = resolve_operand(in_rs2, wb_valid, wb_addr, wb_data, rf_read_data_b);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_rd_wen   <= 1'b0;
      out_payload  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_rs1_data <= rs1_val;
      out_rs2_data <= rs2_val;
      out_rd       <= in_rd;
      out_rd_wen   <= in_rd_wen;
      out_payload  <= in_payload;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  operand_scoreboard u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .set_en         (accept && in_rd_wen && (in_rd != '0)),
    .set_addr       (in_rd),
    .clr_en         (wb_valid && (wb_addr != '0)),
    .clr_addr       (wb_addr),
    .flush_clr_en   (flush && out_valid && out_rd_wen && (out_rd != '0)),
    .flush_clr_addr (out_rd),
    .busy           (busy)
  );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a vector table for single-cycle resolution
// plus hand-written sequences for stalls, backpressure, flush and reset.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_rd_wen;
  logic [31:0] in_payload;
  logic [4:0]  rf_read_addr_a, rf_read_addr_b;
  logic [31:0] rf_read_data_a, rf_read_data_b;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1_data, out_rs2_data;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [31:0] out_payload;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  operand_fetch #(.PAYLOAD_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_rd_wen(in_rd_wen),
    .in_payload(in_payload),
    .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
    .rf_read_data_a(rf_read_data_a), .rf_read_data_b(rf_read_data_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_payload(out_payload)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, wen;
    logic [31:0] rfa, rfb;
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        ordy, fl;
    logic        exp_ready, exp_valid, chk_data;
    logic [31:0] exp_a, exp_b, pay;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_uses_rs1 = 0; in_uses_rs2 = 0; in_rd_wen = 0; in_payload = 0;
    rf_read_data_a = 0; rf_read_data_b = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    #1;
  endtask

  initial begin
    // iv rs1 rs2 rd u1 u2 wen rfa rfb wbv wba wbd ordy fl | ready valid chk a b pay
    vecs[0] = '{1, 1, 2, 3, 1, 1, 0, 32'h11, 32'h22, 0, 0, 0, 1, 0, 1, 1, 1, 32'h11, 32'h22, 32'hA1};
    vecs[1] = '{1, 0, 2, 3, 1, 1, 0, 32'h1234, 32'h22, 0, 0, 0, 1, 0, 1, 1, 1, 32'h0, 32'h22, 32'hA2};
    vecs[2] = '{1, 4, 6, 10, 1, 1, 0, 32'h44, 32'h66, 1, 4, 32'hCAFE, 1, 0, 1, 1, 1, 32'hCAFE, 32'h66, 32'hA3};
    vecs[3] = '{1, 8, 8, 0, 1, 1, 0, 32'h88, 32'h77, 1, 8, 32'h5555, 1, 0, 1, 1, 1, 32'h5555, 32'h5555, 32'hA4};
    vecs[4] = '{1, 0, 0, 0, 1, 1, 1, 32'h1234, 32'h1234, 1, 0, 32'h99, 1, 0, 1, 1, 1, 32'h0, 32'h0, 32'hA5};
    vecs[5] = '{0, 1, 2, 3, 1, 1, 0, 32'h11, 32'h22, 0, 0, 0, 1, 0, 1, 0, 0, 32'h0, 32'h0, 32'hA6};
    vecs[6] = '{1, 1, 2, 3, 1, 1, 0, 32'h11, 32'h22, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0, 32'hA7};
    vecs[7] = '{1, 31, 30, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0, 1, 0, 1, 1, 1, 32'hFFFFFFFF, 32'h80000000, 32'hA8};

    reset = 1;
    idle_inputs();
    in_valid = 1;
    flush = 1;
    wb_valid = 1; wb_addr = 5; wb_data = 32'h1;
    #1;
    check("ready_low_in_reset", in_ready, 0);
    step();
    step();
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", dut.busy, 0);
    check("reset_out_data", {out_rs1_data, out_rs2_data}, 0);
    check("reset_out_meta", {out_rd, out_rd_wen, out_payload}, 0);
    idle_inputs();
    reset = 0;
    #1;

    for (int i = 0; i < 8; i++) begin
      in_valid = vecs[i].iv; in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2; in_rd = vecs[i].rd;
      in_uses_rs1 = vecs[i].u1; in_uses_rs2 = vecs[i].u2; in_rd_wen = vecs[i].wen;
      rf_read_data_a = vecs[i].rfa; rf_read_data_b = vecs[i].rfb;
      wb_valid = vecs[i].wbv; wb_addr = vecs[i].wba; wb_data = vecs[i].wbd;
      out_ready = vecs[i].ordy; flush = vecs[i].fl; in_payload = vecs[i].pay;
      #1;
      check($sformatf("v%0d_rf_addr", i), {rf_read_addr_a, rf_read_addr_b}, {vecs[i].rs1, vecs[i].rs2});
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].exp_ready);
      step();
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_ops", i), {out_rs1_data, out_rs2_data}, {vecs[i].exp_a, vecs[i].exp_b});
        check($sformatf("v%0d_meta", i), {out_rd, out_rd_wen, out_payload},
              {vecs[i].rd, vecs[i].wen, vecs[i].pay});
      end
    end
    idle_inputs();
    #1;
    check("x0_never_busy", dut.busy, 0);

    // back-to-back dependency resolved by bypass
    do_reset();
    in_valid = 1; in_rd = 5; in_rd_wen = 1;
    #1; check("dep_first_ready", in_ready, 1);
    step();
    check("dep_busy5_set", dut.busy[5], 1);
    in_rd = 0; in_rd_wen = 0; in_rs1 = 5; in_uses_rs1 = 1; rf_read_data_a = 32'h0BAD;
    for (int c = 0; c < 3; c++) begin
      #1; check("dep_stall", in_ready, 0);
      step();
    end
    check("dep_drained", out_valid, 0);
    wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    #1; check("dep_wb_ready", in_ready, 1);
    step();
    check("dep_out_valid", out_valid, 1);
    check("dep_bypass_data", out_rs1_data, 32'hDEADBEEF);
    check("dep_busy5_clear", dut.busy[5], 0);
    idle_inputs();

    // backpressure
    do_reset();
    out_ready = 0;
    in_valid = 1; in_rs1 = 1; in_uses_rs1 = 1; rf_read_data_a = 32'h100; in_payload = 1;
    step();
    check("bp_first_valid", out_valid, 1);
    rf_read_data_a = 32'h200; in_payload = 2;
    for (int c = 0; c < 3; c++) begin
      #1; check("bp_ready_low", in_ready, 0);
      step();
      check("bp_hold", {out_valid, out_rs1_data, out_payload}, {1'b1, 32'h100, 32'h1});
    end
    out_ready = 1;
    for (int c = 2; c <= 4; c++) begin
      in_payload = c; rf_read_data_a = 32'h100 * c;
      #1; check("bp_release_ready", in_ready, 1);
      step();
      check("bp_stream", {out_valid, out_rs1_data, out_payload}, {1'b1, 32'h100 * c, c});
    end
    idle_inputs();

    // WAW with same-cycle set and clear
    do_reset();
    in_valid = 1; in_rd = 7; in_rd_wen = 1; in_payload = 32'h70;
    step();
    in_payload = 32'h71;
    #1; check("waw_stall", in_ready, 0);
    step();
    check("waw_drained", out_valid, 0);
    wb_valid = 1; wb_addr = 7; wb_data = 32'h77;
    #1; check("waw_wb_ready", in_ready, 1);
    step();
    check("waw_accepted", {out_valid, out_rd, out_payload}, {1'b1, 5'd7, 32'h71});
    check("waw_set_wins", dut.busy[7], 1);
    wb_valid = 0; in_rd_wen = 0; in_rd = 0; in_rs1 = 7; in_uses_rs1 = 1;
    #1; check("waw_raw_after", in_ready, 0);
    idle_inputs();

    // flush clears held entry and its busy bit
    do_reset();
    out_ready = 0;
    in_valid = 1; in_rd = 9; in_rd_wen = 1;
    step();
    check("fl_busy9_set", dut.busy[9], 1);
    in_valid = 0; flush = 1; out_ready = 1;
    #1; check("fl_ready_low", in_ready, 0);
    step();
    check("fl_out_valid", out_valid, 0);
    check("fl_busy9_clear", dut.busy[9], 0);
    flush = 0; in_valid = 1; in_rd = 0; in_rd_wen = 0; in_rs1 = 9; in_uses_rs1 = 1;
    rf_read_data_a = 32'h999;
    #1; check("fl_no_stall", in_ready, 1);
    step();
    check("fl_issue", {out_valid, out_rs1_data}, {1'b1, 32'h999});
    idle_inputs();

    // reset during a stall
    do_reset();
    in_valid = 1; in_rd = 3; in_rd_wen = 1;
    step();
    in_rd = 0; in_rd_wen = 0; in_rs1 = 3; in_uses_rs1 = 1; rf_read_data_a = 32'h33;
    #1; check("rst_stall", in_ready, 0);
    step();
    reset = 1;
    #1; check("rst_ready_low", in_ready, 0);
    step();
    reset = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", dut.busy, 0);
    check("rst_rs3_ready", in_ready, 1);
    step();
    check("rst_rs3_issue", {out_valid, out_rs1_data}, {1'b1, 32'h33});
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 32, width of the opaque instruction payload carried to execute.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid / in_ready  input / output  1 / 1  decode-side handshake.
REQ-005 in_rs1, in_rs2, in_rd  input  5 each  source and destination register indices.
REQ-006 in_uses_rs1, in_uses_rs2, in_rd_wen  input  1 each  operand-used flags and destination write flag.
REQ-007 in_payload  input  PAYLOAD_W  opaque; passed through unchanged.
REQ-008 rf_read_addr_a, rf_read_addr_b  output  5 each  register-file read addresses.
REQ-009 rf_read_data_a, rf_read_data_b  input  32 each  asynchronous register-file read data.
REQ-010 wb_valid, wb_addr, wb_data  input  1 / 5 / 32  writeback port, identical to the register-file write port.
REQ-011 flush  input  1  discard the held output entry.
REQ-012 out_valid / out_ready  output / input  1 / 1  execute-side handshake.
REQ-013 out_rs1_data, out_rs2_data  output  32 each  resolved operands.
REQ-014 out_rd, out_rd_wen, out_payload  output  5 / 1 / PAYLOAD_W  registered copies of the inputs.

Function
REQ-015 rf_read_addr_a/b SHALL equal in_rs1/in_rs2 combinationally.
REQ-016 Operand resolution: index 0 -> 0; else wb_valid && wb_addr==index -> wb_data (bypass); else register-file data.
REQ-017 Scoreboard: 32 busy bits; bit 0 is always 0.
REQ-018 RAW hazard for rsN: in_uses_rsN && rsN!=0 && busy[rsN] && !(wb_valid && wb_addr==rsN).
REQ-019 WAW hazard: in_rd_wen && in_rd!=0 && busy[in_rd] && !(wb_valid && wb_addr==in_rd).
REQ-020 in_ready = (!out_valid || out_ready) && !hazard && !flush; it SHALL be combinational and SHALL NOT depend on in_valid.
REQ-021 Accept = in_valid && in_ready; on accept the output register SHALL load the resolved operands, rd, rd_wen and payload, with out_valid=1 at the next edge (1-cycle latency).
REQ-022 Out_valid && out_ready without an accept SHALL clear out_valid; if both occur, the new entry replaces the old one (full throughput).
REQ-023 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-024 Accept with in_rd_wen && in_rd!=0 SHALL set busy[in_rd].
REQ-025 wb_valid && wb_addr!=0 SHALL clear busy[wb_addr]; a writeback to a non-busy register SHALL still bypass and SHALL NOT affect the scoreboard.
REQ-026 If a set and a clear target the same index in the same cycle, the set SHALL win.
REQ-027 Flush: out_valid SHALL become 0 at the next edge; if the held entry has out_valid && out_rd_wen && out_rd!=0, its busy bit SHALL be cleared; no accept occurs that cycle.
REQ-028 Flush takes precedence over out_ready.
REQ-029 Captured operands SHALL NOT be refreshed by later writebacks; the hazard rules guarantee they are correct at capture.

Reset
REQ-030 On reset: out_valid=0, all busy bits=0, and out_rs1_data, out_rs2_data, out_rd, out_rd_wen, out_payload=0.
REQ-031 Reset SHALL override flush, accept and writeback in the same cycle.
REQ-032 in_ready SHALL be 0 while reset is high.

Structure
REQ-033 Shared package SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32, and typedefs reg_addr_t and xlen_t; the register file and this block SHALL both use them.
REQ-034 The scoreboard SHALL be a sub-module named operand_scoreboard, with set, clear and flush-clear ports and a 32-bit busy vector output.

Verification
REQ-035 Back-to-back dependency: issue rd=5 (busy), then rs1=5 -> in_ready=0 until wb_valid, wb_addr=5, wb_data=0xDEADBEEF; in that cycle accept with out_rs1_data=0xDEADBEEF (bypass).
REQ-036 x0: rs1=0 with register-file data 0x1234 and wb to addr 0 -> out_rs1_data=0, no stall, busy[0] stays 0.
REQ-037 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0, then one transfer per cycle after release.
REQ-038 WAW plus same-cycle set/clear: busy[7] set, second rd=7 stalls; on wb to addr 7 it is accepted -> busy[7]=1 afterwards.
REQ-039 Flush: held entry rd=9 with out_valid=1 and flush=1 -> out_valid=0 and busy[9]=0 next cycle; a following rs1=9 issues without stall.
REQ-040 Reset mid-stall: busy[3]=1 and a stalled rs1=3 -> after reset, out_valid=0, busy=0, and rs1=3 is accepted immediately.
